freq_meter_100hz: RTL
=====================

# freq_meter_100hz

Period/frequency checker for the slow divided clocks used across the design (nominally 100 Hz). It samples an asynchronous slow input against the 50 MHz system clock and measures each period and high time in system-clock cycles. It raises `locked` once the input is consistently within tolerance of the expected period, and flags a stalled input. It is the measuring end for the clock-divider chain: it verifies in-system what the divider produces.

## Interface
- `EXPECTED_PERIOD`, default 500000: nominal period in clk_50MHz cycles.
- `TOLERANCE`, default 500: allowed absolute deviation, in cycles.
- `TIMEOUT`, default 1000000: cycles without a rising edge before declaring a stall; must exceed `EXPECTED_PERIOD + TOLERANCE`.
- `LOCK_COUNT`, default 4: consecutive in-tolerance periods required for lock (1..15).
- `CNT_W`, default 32: width of counters and outputs.

Ports:
- `clk_50MHz` input, 1 bit: the single clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `sig_in` input, 1 bit: slow signal under test; asynchronous to `clk_50MHz`.
- `period` output, CNT_W bits: last measured period, in cycles.
- `high_time` output, CNT_W bits: cycles `sig_in` was high during that period.
- `period_valid` output, 1 bit: one-cycle pulse when `period`/`high_time` update.
- `locked` output, 1 bit: input is stable and within tolerance.
- `timeout` output, 1 bit: no rising edge for `TIMEOUT` cycles.

## Operation
- Input conditioning:
  - 2-flop synchronizer `s1`→`s2`, then history flop `s3`.
  - `rise = s2 & ~s3`; `fall = ~s2 & s3`.
- Counters:
  - `cnt` saturates at `TIMEOUT`.
  - `hcnt` counts cycles with `s2`=1 since the last rise; it saturates at `TIMEOUT`.
- FSM states: IDLE, MEASURE, STALL.
  - **IDLE** (after reset): on `rise` → MEASURE, `cnt`←1, `hcnt`←1. No `period_valid`.
  - **MEASURE**, per cycle:
    - On `rise`: `period`←`cnt`, `high_time`←`hcnt`, `period_valid`←1; then `cnt`←1, `hcnt`←1.
    - Otherwise: `cnt`←`cnt`+1, and `hcnt`←`hcnt`+`s2`.
    - When `cnt` = `TIMEOUT` and there is no `rise` → STALL.
  - **STALL**:
    - Entry: `timeout`←1, `locked`←0, lock run cleared.
    - On `rise` → MEASURE with `cnt`←1, `hcnt`←1, `timeout`←0. This edge is treated as a first edge: no `period_valid`.
- Lock tracking:
  - A measured period is in tolerance iff `EXPECTED_PERIOD-TOLERANCE` ≤ `period` ≤ `EXPECTED_PERIOD+TOLERANCE`. Compare unsigned at CNT_W+1 bits; a lower bound below 0 clamps to 0.
  - On each `period_valid`:
    - In tolerance: `run`←min(`run`+1, `LOCK_COUNT`).
    - Out of tolerance: `run`←0 and `locked`←0.
  - `locked`←1 when `run` reaches `LOCK_COUNT`. Evaluate in the same cycle as the `period` update, so `locked` rises coincident with the `LOCK_COUNT`-th `period_valid`.
- Simultaneous events:
  - `rise` on the cycle `cnt` would reach `TIMEOUT`: `rise` wins. The period is recorded, the FSM stays in MEASURE, and no timeout occurs.
  - `fall` and `rise` cannot coincide; no special handling.
- Reset (at any time, including mid-measurement):
  - FSM→IDLE; all counters and `run` cleared.
  - `period`=0, `high_time`=0, `period_valid`=0, `locked`=0, `timeout`=0; `s1`/`s2`/`s3`=0.
  - The first measurement after reset needs two rising edges.

## Timing
- Detection latency: `sig_in` rises and is first sampled high at clock edge N. `rise` is combinationally true after edge N+1. `period`, `high_time`, and `period_valid` update at edge N+2.
- `period_valid` is high for exactly one cycle per accepted edge.
- `locked` and `timeout` are registered and level-held.
- Period resolution is 1 cycle. A jitter-free input of P cycles measures exactly P.
- The FSM evaluates `rise` only; `fall` is informational. `hcnt` uses `s2`, so `high_time` equals the synchronized high width.

## Test plan
Bench parameters: `EXPECTED_PERIOD`=100, `TOLERANCE`=2, `TIMEOUT`=300, `LOCK_COUNT`=4.

1. **Square wave at period 100, 40 high:**
   - Required: first `period_valid` on the 2nd rise.
   - Every pulse: `period`=100, `high_time`=40.
   - `locked`=1 coincident with the 4th `period_valid`; `timeout`=0 throughout.
2. **Locked at 100, then one period of 110, then back to 100:**
   - Required: `locked` drops on the 110 measurement (`period`=110).
   - `locked` reasserts on the 4th subsequent 100-cycle measurement.
3. **Boundaries:**
   - Periods of 98 and 102 count toward lock.
   - Periods of 97 and 103 reset `run`, and `locked` stays 0.
4. **Stall:**
   - Hold `sig_in` low after lock. Required: `timeout`=1 and `locked`=0 exactly 300 cycles after the last detected rise.
   - Next rise: `timeout`=0, no `period_valid`.
   - The following rise gives a valid `period`.
5. **Rise exactly at cnt=300:**
   - Period-300 input. Required: `period`=300 reported, `timeout` never asserts.
6. **Reset mid-measurement:**
   - Assert `reset` 50 cycles into a period while locked. Required: all outputs 0 immediately (asynchronously).
   - After release, two rises are needed before `period_valid`.

Source files
------------

// File: rtl/freq_meter_100hz.sv
// Measures period and high time of an asynchronous slow clock in clk_50MHz cycles; results update
// two cycles after the first synchronized high sample. Lock and stall detection are included. No backpressure.
module freq_meter_100hz #(
    parameter int EXPECTED_PERIOD = 500000,
    parameter int TOLERANCE       = 500,
    parameter int TIMEOUT         = 1000000,
    parameter int LOCK_COUNT      = 4,
    parameter int CNT_W           = 32
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, MEASURE, STALL} state_t;

    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   LO_BOUND = (EXPECTED_PERIOD > TOLERANCE) ?
                                            (CNT_W+1)'(EXPECTED_PERIOD - TOLERANCE) : '0;
    localparam logic [CNT_W:0]   HI_BOUND = (CNT_W+1)'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_COUNT);

    state_t           state, state_next;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt, hcnt, cnt_inc, hcnt_inc;
    logic [3:0]       run, run_next;
    logic             in_tol;

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Both counters stop at the stall threshold so they can never wrap.
    assign cnt_inc  = (cnt == TO_VAL) ? cnt : cnt + CNT_W'(1);
    assign hcnt_inc = (hcnt == TO_VAL || !s2) ? hcnt : hcnt + CNT_W'(1);

    assign in_tol = ({1'b0, cnt} >= LO_BOUND) && ({1'b0, cnt} <= HI_BOUND);

    always_comb begin
        run_next = 4'd0;
        if (in_tol)
            run_next = (run >= LOCK_N) ? LOCK_N : run + 4'd1;
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rise) state_next = MEASURE;
            MEASURE: if (!rise && cnt == TO_VAL) state_next = STALL;
            STALL:   if (rise) state_next = MEASURE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            hcnt         <= '0;
            run          <= 4'd0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt  <= CNT_W'(1);
                        hcnt <= CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period       <= cnt;
                        high_time    <= hcnt;
                        period_valid <= 1'b1;
                        cnt          <= CNT_W'(1);
                        hcnt         <= CNT_W'(1);
                        run          <= run_next;
                        locked       <= (run_next == LOCK_N);
                    end else begin
                        cnt  <= cnt_inc;
                        hcnt <= hcnt_inc;
                        if (cnt == TO_VAL) begin
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            run     <= 4'd0;
                        end
                    end
                end
                STALL: begin
                    // The edge that ends a stall only restarts measurement.
                    if (rise) begin
                        cnt     <= CNT_W'(1);
                        hcnt    <= CNT_W'(1);
                        timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
